station_arbiter: RTL

STATION_ARBITER -- requirements
Module: station_arbiter

---
 rtl/station_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/station_arbiter.sv
// Round-robin arbiter that lets several scanner stations share one code-lookup
// database: grant one station, issue its code, wait for a result or a timeout, report.
module station_arbiter #(
    parameter int NUM_STATIONS = 4,
    parameter int CODE_W       = 4,
    parameter int TIMEOUT      = 16,
    localparam int GW          = (NUM_STATIONS > 1) ? $clog2(NUM_STATIONS) : 1,
    localparam int CW          = $clog2(TIMEOUT) + 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_STATIONS-1:0]        req,
    input  logic [NUM_STATIONS*CODE_W-1:0] code,
    output logic                           db_start,
    output logic [CODE_W-1:0]              db_code,
    input  logic                           db_ready,
    input  logic                           db_match,
    output logic [NUM_STATIONS-1:0]        done,
    output logic                           ok,
    output logic                           timeout,
    output logic [GW-1:0]                  grant_id,
    output logic                           busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [GW-1:0]   last_grant;
    logic [CW-1:0]   wcnt;
    logic            ok_q;
    logic            to_q;
    logic [GW-1:0]   pick;
    logic            pick_valid;
    logic            wait_expired;

    assign wait_expired = (wcnt == CW'(TIMEOUT - 1));

    // Walk downward so the nearest requester after last_grant is assigned last and wins.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        for (int i = NUM_STATIONS; i >= 1; i--) begin
            if (req[(int'(last_grant) + i) % NUM_STATIONS]) begin
                pick_valid = 1'b1;
                pick       = GW'((int'(last_grant) + i) % NUM_STATIONS);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (pick_valid) state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (db_ready || wait_expired) state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= GW'(NUM_STATIONS - 1);
            grant_id   <= '0;
            db_code    <= '0;
            wcnt       <= '0;
            ok_q       <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        grant_id <= pick;
                        db_code  <= code[int'(pick)*CODE_W +: CODE_W];
                        ok_q     <= 1'b0;
                        to_q     <= 1'b0;
                    end
                end
                S_ISSUE: wcnt <= '0;
                S_WAIT: begin
                    // A result arriving on the last allowed cycle beats the timeout.
                    if (db_ready) begin
                        ok_q <= db_match;
                        to_q <= 1'b0;
                    end else if (wait_expired) begin
                        ok_q <= 1'b0;
                        to_q <= 1'b1;
                    end else if (wcnt != '1) begin
                        wcnt <= wcnt + CW'(1);
                    end
                end
                S_RESP: last_grant <= grant_id;
                default: ;
            endcase
        end
    end

    assign db_start = (state == S_ISSUE);
    assign busy     = (state != S_IDLE);
    assign ok       = (state == S_RESP) && ok_q;
    assign timeout  = (state == S_RESP) && to_q;

    always_comb begin
        done = '0;
        if (state == S_RESP) done[grant_id] = 1'b1;
    end

endmodule
